// File: rtl/io_pkg.sv
// io_pkg: shared register map and defaults for the button/switch input peripheral
package io_pkg;
  localparam logic [3:0] SW_OFS  = 4'd0;
  localparam logic [3:0] BTN_OFS = 4'd4;
  localparam logic [3:0] EVT_OFS = 4'd8;
  localparam logic [3:0] CNT_OFS = 4'd12;
  localparam logic [31:0] IO_BASE_ADDR = 32'h0000_0400;
  typedef enum logic [1:0] {
    REG_SW  = 2'b00,
    REG_BTN = 2'b01,
    REG_EVT = 2'b10,
    REG_CNT = 2'b11
  } io_reg_e;
endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer: 2-flop synchronizer plus stable-level debounce for one button
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic commit;
  // rise is combinational so the event latch sets on the same edge as level
  assign commit = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise = commit && sync[1];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) cnt <= '0;
      else if (commit) begin
        level <= sync[1];
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/button_switch_reader.sv
// button_switch_reader: memory-mapped buttons/switches with press events and counter
module button_switch_reader
  import io_pkg::*;
#(
  parameter int          N_BTN           = 4,
  parameter int          N_SW            = 8,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter logic [31:0] BASE_ADDR       = IO_BASE_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [31:0]      Addr,
  input  logic             MemRead,
  output logic             Hit,
  output logic [31:0]      ReadData,
  output logic             irq_pending
);
  logic [N_SW-1:0] sw_meta, sw_sync;
  logic [N_BTN-1:0] stab, rise, evt, evt_clr;
  logic [7:0] press_cnt;
  io_reg_e reg_sel;
  logic unused_addr;
  assign unused_addr = ^Addr[1:0];
  genvar i;
  generate
    for (i = 0; i < N_BTN; i++) begin : g_btn
      btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_raw[i]),
        .level(stab[i]),
        .rise (rise[i])
      );
    end
  endgenerate
  assign Hit = Addr[31:4] == BASE_ADDR[31:4];
  assign reg_sel = io_reg_e'(Addr[3:2]);
  assign ReadData = !Hit               ? 32'd0 :
                    reg_sel == REG_SW  ? 32'(sw_sync) :
                    reg_sel == REG_BTN ? 32'(stab) :
                    reg_sel == REG_EVT ? 32'(evt) : 32'(press_cnt);
  // only the bits actually returned by this read are cleared; a same-edge rise wins
  assign evt_clr = (MemRead && Hit && reg_sel == REG_EVT) ? evt : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sw_meta     <= '0;
      sw_sync     <= '0;
      evt         <= '0;
      press_cnt   <= '0;
      irq_pending <= 1'b0;
    end else begin
      sw_meta     <= sw_raw;
      sw_sync     <= sw_meta;
      evt         <= (evt & ~evt_clr) | rise;
      press_cnt   <= press_cnt + 8'($countones(rise));
      irq_pending <= |evt;
    end
endmodule

// File: tb/tb_button_switch_reader.sv
// tb_button_switch_reader: directed self-checking bench for button_switch_reader
module tb_button_switch_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] btn_raw = '0;
  logic [7:0] sw_raw = '0;
  logic [31:0] Addr = 32'h0000_0400;
  logic MemRead = 1'b0;
  logic Hit;
  logic [31:0] ReadData;
  logic irq_pending;
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [31:0] BASE = 32'h0000_0400;

  button_switch_reader #(.N_BTN(4), .N_SW(8), .DEBOUNCE_CYCLES(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw), .Addr(Addr),
    .MemRead(MemRead), .Hit(Hit), .ReadData(ReadData), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    MemRead = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [3:0] ofs, input logic [31:0] exp);
    Addr = BASE + 32'(ofs);
    MemRead = 1'b0;
    #1 check(tag, ReadData, exp);
  endtask

  task automatic take(input string tag, input logic [3:0] ofs, input logic [31:0] exp);
    Addr = BASE + 32'(ofs);
    MemRead = 1'b1;
    #1 check(tag, ReadData, exp);
  endtask

  logic pat [10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    step(2);
    reset = 1'b0;
    sw_raw = 8'hFF;
    btn_raw[0] = 1'b1;
    step(3);
    peek("pre_reset_sw", 4'd0, 32'hFF);
    #2 reset = 1'b1;
    btn_raw = '0;
    sw_raw = '0;
    peek("rst_sw", 4'd0, 0);
    peek("rst_btn", 4'd4, 0);
    peek("rst_evt", 4'd8, 0);
    peek("rst_cnt", 4'd12, 0);
    check("rst_irq", irq_pending, 0);
    step(2);
    reset = 1'b0;
    step(6);
    peek("post_rst_evt", 4'd8, 0);
    peek("post_rst_cnt", 4'd12, 0);
    sw_raw = 8'hA5;
    step(1);
    peek("sw_1edge", 4'd0, 0);
    step(1);
    peek("sw_2edge", 4'd0, 32'hA5);
    peek("sw_btn_ofs", 4'd4, 0);
    Addr = 32'h0000_0800;
    #1 check("miss_hit", Hit, 0);
    check("miss_data", ReadData, 0);
    for (int i = 0; i < 10; i++) begin
      btn_raw[0] = pat[i];
      step(1);
      if (i == 4) peek("bounce_run1", 4'd4, 0);
      if (i == 8) peek("bounce_pre", 4'd4, 0);
      if (i == 9) begin
        peek("bounce_commit", 4'd4, 1);
        check("bounce_irq_lag", irq_pending, 0);
      end
    end
    peek("bounce_cnt", 4'd12, 1);
    step(1);
    check("bounce_irq", irq_pending, 1);
    take("clr0_read", 4'd8, 1);
    step(1);
    peek("clr0_after", 4'd8, 0);
    btn_raw[2] = 1'b1;
    step(6);
    peek("b2_evt", 4'd8, 4);
    step(1);
    check("b2_irq", irq_pending, 1);
    take("b2_read", 4'd8, 4);
    step(1);
    peek("b2_cleared", 4'd8, 0);
    step(1);
    check("b2_irq_clr", irq_pending, 0);
    peek("b2_cnt", 4'd12, 2);
    btn_raw[1] = 1'b1;
    step(6);
    peek("b1_evt", 4'd8, 2);
    btn_raw[1] = 1'b0;
    step(6);
    peek("b1_release_stab", 4'd4, 5);
    peek("b1_release_cnt", 4'd12, 3);
    btn_raw[1] = 1'b1;
    step(5);
    take("coll_read", 4'd8, 2);
    step(1);
    peek("coll_evt", 4'd8, 2);
    peek("coll_cnt", 4'd12, 4);
    btn_raw[0] = 1'b0;
    btn_raw[1] = 1'b0;
    step(6);
    for (int k = 0; k < 251; k++) begin
      btn_raw[1] = 1'b1;
      step(6);
      btn_raw[1] = 1'b0;
      step(6);
    end
    peek("wrap_pre_cnt", 4'd12, 32'hFF);
    take("wrap_clr", 4'd8, 2);
    step(1);
    btn_raw[0] = 1'b1;
    btn_raw[3] = 1'b1;
    step(6);
    peek("wrap_cnt", 4'd12, 32'h01);
    peek("wrap_evt", 4'd8, 32'h9);
    peek("wrap_stab", 4'd4, 32'hD);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/button_switch_reader.md
# button_switch_reader

Memory-mapped input peripheral for the single-cycle ARM core. It is the input-side counterpart of the LED output path: it brings board push-buttons and slide switches into the processor's data-memory read space. The block synchronizes all raw inputs and debounces the buttons. It latches press events, which software clears by reading them, and it keeps a wrapping press counter. It sits beside data memory and is selected by address decode on loads (LDR).

## Interface
- `N_BTN`, default 4: number of push-buttons.
- `N_SW`, default 8: number of slide switches.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to accept a button level. This is 10 ms at 50 MHz; benches use 4.
- `BASE_ADDR`, default 32'h0000_0400: base of the 16-byte register window.
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high.
- `btn_raw`, input, N_BTN: raw buttons. Active-high and asynchronous to clk.
- `sw_raw`, input, N_SW: raw switches. Asynchronous to clk.
- `Addr`, input, 32: ALUResult (the data address from the core).
- `MemRead`, input, 1: a load is executing this cycle.
- `Hit`, output, 1: `Addr[31:4] == BASE_ADDR[31:4]`. Combinational.
- `ReadData`, output, 32: register read data. Combinational. It is 0 when `Hit` is 0.
- `irq_pending`, output, 1: OR of all event bits. Registered.

## Operation
- Synchronization: every `btn_raw` and `sw_raw` bit passes through a 2-flop synchronizer. Switches are not debounced.
- Debounce, per button:
  - Each button has a stable level `stab` and a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)+1`.
  - If the synced level equals `stab`: `cnt <= 0`.
  - Otherwise `cnt` increments.
  - When `cnt == DEBOUNCE_CYCLES-1` and the level still differs: `stab <= synced` and `cnt <= 0`.
  - Any agreeing cycle restarts the count.
- Event latch:
  - A 0→1 commit of `stab[i]` sets `evt[i]` at the same edge.
  - The bit is sticky until cleared.
  - Release (1→0) produces no event.
- Clear-on-read: a cycle with `MemRead && Hit && Addr[3:2]==2'b10` clears every `evt` bit that `ReadData` returned in that cycle.
  - If a new press commits on the same edge for the same bit, set wins and the bit stays 1.
- Press counter: `press_cnt` is 8 bits. It increments by the number of 0→1 commits in the cycle, which can be several when buttons commit simultaneously. It wraps modulo 256 and saturates at no value.
- Register map, selected by `Addr[3:2]`; `Addr[1:0]` is ignored and unused bits read 0:
  - 00: `{0, sw_sync}`.
  - 01: `{0, stab}`.
  - 10: `{0, evt}` (clear-on-read).
  - 11: `{0, press_cnt}`.
- Writes are ignored. The block has no write port.

## Timing
- Reset values: all synchronizer flops, `stab`, `cnt`, `evt`, `press_cnt` and `irq_pending` are 0. `ReadData` is therefore 0 for every offset right after reset.
- Reset mid-debounce discards the partial count. No event is generated.
- Switch latency: a `sw_raw` change before edge k is visible in `ReadData` after edge k+1, because of the 2 flops.
- Button latency:
  - Raw rise held clean before edge k: synced after edge k+1.
  - `stab` and `evt` set at edge k+1+`DEBOUNCE_CYCLES`.
  - `irq_pending` is 1 one edge later.
- Read is zero-wait: `ReadData` is valid in the same cycle as `Addr`, which matches single-cycle data memory. The clear takes effect at the end of that cycle.
- A glitch shorter than `DEBOUNCE_CYCLES` synced cycles never changes `stab`.

## Structure
- Package `io_pkg`:
  - Register offsets: `SW_OFS`=0, `BTN_OFS`=4, `EVT_OFS`=8, `CNT_OFS`=12.
  - `io_reg_e` enum for `Addr[3:2]`.
  - Default `BASE_ADDR` constant.
- Sub-module `btn_debouncer`: synchronizer, counter and `stab` for one bit. It outputs `level` and a one-cycle `rise` pulse. It is instantiated N_BTN times with `generate`.
- The top module holds the switch synchronizer, the event/counter logic and the read mux.

## Test plan
Benches set `DEBOUNCE_CYCLES`=4.
- **Reset:** assert reset asynchronously mid-cycle → `ReadData`=0 at all four offsets and `irq_pending`=0.
- **Switches:** `sw_raw`=8'hA5 → read offset 0 returns 32'h0000_00A5 two edges later. Offset 4 returns 0.
- **Bounce:** `btn_raw[0]` high 3 cycles, low 1, then high 6 → `stab[0]` rises only at the 4th synced-high cycle of the final run. `press_cnt`=1.
- **Clear-on-read:** press btn 2 → offset 8 reads 32'h4 and `irq_pending`=1. The next read of offset 8 returns 0 and `irq_pending`=0.
- **Set/clear collision:** hold `evt[1]`=1. Read offset 8 on the same edge that btn 1 commits a new press → `evt[1]` stays 1 and `press_cnt` increments.
- **Multi-button and wrap:** buttons 0 and 3 commit on the same edge with `press_cnt`=8'hFF → `press_cnt`=8'h01 and `evt`=4'b1001.
